// File: rtl/admm_pkg.sv
// Shared types and default widths for the ADMM temp-RAM clip sweep.
// Used by admm_clip_sweep_ctrl (optional sat counter: ADMM_CLIP_SAT_CNT_EN).
package admm_pkg;

    localparam int unsigned DATA_W     = 21;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned ADDR_RANGE = 18;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sweep_state_e;

    typedef enum logic [1:0] {
        CLIP_NONE,
        CLIP_LO,
        CLIP_HI
    } clip_flag_e;

endpackage

// File: rtl/admm_clip_unit.sv
// Combinational box projection: clamps a signed word to [lo, hi], lo taking priority.
module admm_clip_unit
    import admm_pkg::*;
#(
    parameter int unsigned DataWidth = DATA_W
) (
    input  logic [DataWidth-1:0] i_q,
    input  logic [DataWidth-1:0] i_lo,
    input  logic [DataWidth-1:0] i_hi,
    output logic [DataWidth-1:0] o_clamped_c,
    output logic                 o_sat_c
);

    clip_flag_e w_flag;

    // Lower bound wins, so lo > hi still yields a deterministic result.
    always_comb begin
        w_flag = CLIP_NONE;
        if ($signed(i_q) < $signed(i_lo)) begin
            w_flag = CLIP_LO;
        end else if ($signed(i_q) > $signed(i_hi)) begin
            w_flag = CLIP_HI;
        end
    end

    always_comb begin
        o_clamped_c = i_q;
        case (w_flag)
            CLIP_LO: o_clamped_c = i_lo;
            CLIP_HI: o_clamped_c = i_hi;
            default: o_clamped_c = i_q;
        endcase
    end

    assign o_sat_c = (w_flag != CLIP_NONE);

endmodule

// File: rtl/admm_clip_sweep_ctrl.sv
// In-place clamp sweep over the ADMM temp RAM: read on port 0, write clamped value on port 1.
// Define ADMM_CLIP_SAT_CNT_EN to add the sat_count output and its counter.
module admm_clip_sweep_ctrl
    import admm_pkg::*;
#(
    parameter int unsigned DataWidth    = DATA_W,
    parameter int unsigned AddressWidth = ADDR_W,
    parameter int unsigned AddressRange = ADDR_RANGE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [AddressWidth-1:0] len,
    input  logic [DataWidth-1:0]    lo,
    input  logic [DataWidth-1:0]    hi,
    output logic                    busy,
    output logic                    done,
    output logic [AddressWidth-1:0] ram_address0,
    output logic                    ram_ce0,
    output logic                    ram_we0,
    output logic [DataWidth-1:0]    ram_d0,
    input  logic [DataWidth-1:0]    ram_q0,
    output logic [AddressWidth-1:0] ram_address1,
    output logic                    ram_ce1,
    output logic                    ram_we1,
    output logic [DataWidth-1:0]    ram_d1
`ifdef ADMM_CLIP_SAT_CNT_EN
    ,
    output logic [AddressWidth:0]   sat_count
`endif
);

    localparam int unsigned AW    = AddressWidth;
    localparam int unsigned CNT_W = AddressWidth + 1;

    sweep_state_e r_state;
    sweep_state_e w_state_nxt;

    logic [AW-1:0]        r_len;
    logic [AW-1:0]        w_len_nxt;
    logic [AW-1:0]        w_len_clip;
    logic [DataWidth-1:0] r_lo;
    logic [DataWidth-1:0] w_lo_nxt;
    logic [DataWidth-1:0] r_hi;
    logic [DataWidth-1:0] w_hi_nxt;
    logic [AW-1:0]        r_idx;
    logic [AW-1:0]        w_idx_nxt;

    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_ce0;
    logic                 w_ce0_nxt;
    logic [AW-1:0]        r_addr0;
    logic [AW-1:0]        w_addr0_nxt;

    logic                 r_wr_valid;
    logic [AW-1:0]        r_wr_addr;

    logic [DataWidth-1:0] w_clamped;
    logic                 w_sat;

    assign w_len_clip = (len > AW'(AddressRange)) ? AW'(AddressRange) : len;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_idx is the next read index; the first read is launched straight from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_lo_nxt    = r_lo;
        w_hi_nxt    = r_hi;
        w_idx_nxt   = r_idx;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_ce0_nxt   = 1'b0;
        w_addr0_nxt = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_len_nxt = w_len_clip;
                    w_lo_nxt  = lo;
                    w_hi_nxt  = hi;
                    if (w_len_clip == '0) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = RUN;
                        w_busy_nxt  = 1'b1;
                        w_ce0_nxt   = 1'b1;
                        w_addr0_nxt = '0;
                        w_idx_nxt   = AW'(1);
                    end
                end
            end
            RUN: begin
                w_busy_nxt = 1'b1;
                if (r_idx < r_len) begin
                    w_ce0_nxt   = 1'b1;
                    w_addr0_nxt = r_idx;
                    w_idx_nxt   = r_idx + AW'(1);
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_state_nxt = DONE;
                w_done_nxt  = 1'b1;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Write port trails the read port by exactly one index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len      <= '0;
            r_lo       <= '0;
            r_hi       <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ce0      <= 1'b0;
            r_addr0    <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
        end else begin
            r_len      <= w_len_nxt;
            r_lo       <= w_lo_nxt;
            r_hi       <= w_hi_nxt;
            r_idx      <= w_idx_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_ce0      <= w_ce0_nxt;
            r_addr0    <= w_addr0_nxt;
            r_wr_valid <= r_ce0;
            r_wr_addr  <= r_addr0;
        end
    end

    admm_clip_unit #(
        .DataWidth (DataWidth)
    ) u_clip (
        .i_q         (ram_q0),
        .i_lo        (r_lo),
        .i_hi        (r_hi),
        .o_clamped_c (w_clamped),
        .o_sat_c     (w_sat)
    );

    // In-range words pass straight through; write data is forced to 0 when no write is due.
    always_comb begin
        ram_d1 = '0;
        if (r_wr_valid) begin
            ram_d1 = w_sat ? w_clamped : ram_q0;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign ram_address0 = r_addr0;
    assign ram_ce0      = r_ce0;
    assign ram_we0      = 1'b0;
    assign ram_d0       = '0;
    assign ram_address1 = r_wr_addr;
    assign ram_ce1      = r_wr_valid;
    assign ram_we1      = r_wr_valid;

`ifdef ADMM_CLIP_SAT_CNT_EN
    logic [CNT_W-1:0] r_sat_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat_cnt <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_sat_cnt <= '0;
        end else if (r_wr_valid && w_sat) begin
            r_sat_cnt <= r_sat_cnt + CNT_W'(1);
        end
    end

    assign sat_count = r_sat_cnt;
`endif

endmodule

// File: doc/admm_clip_sweep_ctrl.md
# admm_clip_sweep_ctrl

Sequencer for the ADMM solver's dual-port temp RAM (21-bit signed words, 18 entries). On a start pulse it sweeps the first `len` entries: it reads each word on port 0, clamps it to [lo, hi], and writes the result back on port 1. This implements the box projection of the z-update in place. It sits between the solver top-level FSM and the temp RAM, and owns both RAM ports while busy.

## Interface
- DataWidth, 21, RAM word width; two's-complement signed
- AddressWidth, 5, RAM address width
- AddressRange, 18, number of RAM entries
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a sweep; sampled only in IDLE
- len  in  AddressWidth  number of entries to sweep, starting at address 0; sampled with start
- lo, hi  in  DataWidth  signed clamp bounds; sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- ram_address0  out  AddressWidth  read address
- ram_ce0  out  1  read enable
- ram_we0  out  1  constant 0
- ram_d0  out  DataWidth  constant 0
- ram_q0  in  DataWidth  read data, valid one cycle after ram_ce0
- ram_address1  out  AddressWidth  write address
- ram_ce1, ram_we1  out  1  write strobe; both asserted together
- ram_d1  out  DataWidth  clamped write data
- sat_count  out  AddressWidth+1  entries clamped in the last sweep (only with the macro; see Configuration)

## Operation
- States are IDLE, RUN, DRAIN, DONE.
- IDLE, start=1: latch `len` (clipped to AddressRange), `lo` and `hi`, and clear the read index.
  - If latched len=0, go to DONE.
  - Otherwise go to RUN.
- RUN: each cycle, issue a read at index i (ce0=1, address0=i), then increment i.
  - The registered pair (valid, i) from the previous cycle drives the write in the current cycle: address1 = previous i, d1 = clamp(ram_q0).
  - After the read at i=len-1 is issued, go to DRAIN.
- DRAIN: no read; perform the final write; go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- Clamp rule, signed compare:
  - q<lo gives lo;
  - otherwise q>hi gives hi;
  - otherwise q unchanged.
  - If lo>hi the same priority still applies: every q<lo becomes lo and every other q>hi becomes hi. The result is deterministic and is not flagged.
- start while not IDLE is ignored. No queueing.
- A read and a write never target the same address in one cycle, because the write lags the read by exactly one index.
- Addresses ≥ len are never touched.

## Timing
- Start is accepted at cycle 0 (IDLE, start=1).
- Reads occur at cycles 1..len.
- Writes occur at cycles 2..len+1.
- done is high at cycle len+2. Total latency is len+2 cycles.
- len=0: done is high at cycle 1. No RAM strobes, and busy stays 0.
- busy is high for cycles 1..len+1.
- A new start is accepted in the cycle after done (IDLE).
- Throughput is one entry per cycle. There is no stall input; the RAM is assumed dedicated while busy.
- Reset value of every output: busy=0, done=0, all ram_* = 0, sat_count=0. The state register returns to IDLE.
- Reset asserted mid-sweep aborts the sweep immediately, and any write in flight is dropped. RAM contents are partially updated; the owner re-runs the sweep.

## Configuration
- ADMM_CLIP_SAT_CNT_EN defined:
  - sat_count is present. It is cleared when start is accepted and increments once per write whose value was clamped (q<lo or q>hi).
  - It is final in the done cycle and holds until the next accepted start.
- Not defined: sat_count and its counter are removed from the port list and the logic. All other behaviour is identical.

## Structure
- Package admm_pkg holds:
  - the FSM state typedef (IDLE, RUN, DRAIN, DONE);
  - default width constants (21, 5, 18);
  - the clamp-result flag typedef.
- Sub-module admm_clip_unit is combinational. It takes q, lo, hi and produces the clamped value plus a sat flag. It is instanced once, on the write path.

## Test plan
- RAM preset 0..17 = {-5,0,3,10,…}, lo=-2, hi=4, len=18:
  - entries become {-2,0,3,4,…};
  - done at cycle 20;
  - sat_count equals the number of out-of-range entries.
- len=0, start: done at cycle 1, busy never 1, no ce0/ce1 strobes.
- len=3 over a RAM preset with 7 at every address, lo=hi=0:
  - addresses 0..2 become 0, addresses 3..17 stay 7;
  - writes occur at cycles 2, 3, 4.
- start held high through a sweep: exactly one sweep runs. A second start pulse in the cycle after done starts a second sweep.
- lo=5, hi=1, values {0,3,9}:
  - results {5,5,1} (0<lo gives 5; 3<lo gives 5; 9 is not <lo and >hi, so it gives 1);
  - sat_count=3.
- reset low at cycle 5 of a len=18 sweep:
  - all outputs are 0 while reset is low;
  - addresses ≥4 are untouched;
  - a fresh start after reset releases completes normally.
